// File: rtl/sim_memory_arbiter.sv
// Two-port arbiter in front of the single simulation memory port.
// Forwards the winning request in the same cycle and tracks outstanding reads
// in an in-order tag FIFO, so each read response goes back to its issuer.
module sim_memory_arbiter #(
  parameter int unsigned P_TAG_DEPTH   = 8,
  parameter int unsigned P_TAG_DEPTH_N = 3,
  parameter bit          P_FIXED_PRIO  = 1'b0
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  // requester 0
  input  logic        iREQ0_REQ,
  output logic        oREQ0_LOCK,
  input  logic [1:0]  iREQ0_ORDER,
  input  logic        iREQ0_RW,
  input  logic [25:0] iREQ0_ADDR,
  input  logic [31:0] iREQ0_DATA,
  output logic        oREQ0_VALID,
  input  logic        iREQ0_LOCK,
  output logic [63:0] oREQ0_DATA,
  // requester 1
  input  logic        iREQ1_REQ,
  output logic        oREQ1_LOCK,
  input  logic [1:0]  iREQ1_ORDER,
  input  logic        iREQ1_RW,
  input  logic [25:0] iREQ1_ADDR,
  input  logic [31:0] iREQ1_DATA,
  output logic        oREQ1_VALID,
  input  logic        iREQ1_LOCK,
  output logic [63:0] oREQ1_DATA,
  // memory port
  output logic        oMEMORY_REQ,
  input  logic        iMEMORY_LOCK,
  output logic [1:0]  oMEMORY_ORDER,
  output logic        oMEMORY_RW,
  output logic [25:0] oMEMORY_ADDR,
  output logic [31:0] oMEMORY_DATA,
  input  logic        iMEMORY_VALID,
  output logic        oMEMORY_LOCK,
  input  logic [63:0] iMEMORY_DATA,
  output logic        oERROR
);

  localparam int unsigned CNT_W = P_TAG_DEPTH_N + 1;
  localparam int unsigned PTR_W = P_TAG_DEPTH_N;

  logic                   last_q, last_d;
  logic [P_TAG_DEPTH-1:0] tag_q, tag_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   error_q, error_d;

  logic win1_c;
  logic full_c;
  logic empty_c;
  logic base_lock_c;
  logic acc0_c;
  logic acc1_c;
  logic push_c;
  logic pop_c;
  logic head_c;
  logic mem_lock_c;

  // Arbitration, request locks and forwarding of the winner's fields
  always_comb begin
    full_c      = (cnt_q == CNT_W'(P_TAG_DEPTH));
    empty_c     = (cnt_q == '0);
    win1_c      = iREQ1_REQ & (~iREQ0_REQ | (~P_FIXED_PRIO & ~last_q));
    base_lock_c = ~inRESET | iMEMORY_LOCK | full_c;
    oREQ0_LOCK  = base_lock_c | win1_c;
    oREQ1_LOCK  = base_lock_c | ~win1_c;
    acc0_c      = iREQ0_REQ & ~oREQ0_LOCK;
    acc1_c      = iREQ1_REQ & ~oREQ1_LOCK;
    push_c      = (acc0_c & ~iREQ0_RW) | (acc1_c & ~iREQ1_RW);
    oMEMORY_REQ   = acc0_c | acc1_c;
    oMEMORY_ORDER = win1_c ? iREQ1_ORDER : iREQ0_ORDER;
    oMEMORY_RW    = win1_c ? iREQ1_RW    : iREQ0_RW;
    oMEMORY_ADDR  = win1_c ? iREQ1_ADDR  : iREQ0_ADDR;
    oMEMORY_DATA  = win1_c ? iREQ1_DATA  : iREQ0_DATA;
  end

  // Response routing by the tag at the FIFO head; a stalled head holds the memory
  always_comb begin
    head_c       = tag_q[rd_ptr_q];
    mem_lock_c   = ~empty_c & (head_c ? iREQ1_LOCK : iREQ0_LOCK);
    oMEMORY_LOCK = mem_lock_c;
    pop_c        = iMEMORY_VALID & ~empty_c & ~mem_lock_c;
    oREQ0_VALID  = inRESET & iMEMORY_VALID & ~empty_c & ~head_c;
    oREQ1_VALID  = inRESET & iMEMORY_VALID & ~empty_c & head_c;
    oREQ0_DATA   = iMEMORY_DATA;
    oREQ1_DATA   = iMEMORY_DATA;
    oERROR       = inRESET & error_q;
  end

  // Next-state for grant history, tag FIFO and sticky error
  always_comb begin
    last_d   = last_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    error_d  = error_q | (iMEMORY_VALID & empty_c);
    if (acc0_c) begin
      last_d = 1'b0;
    end
    if (acc1_c) begin
      last_d = 1'b1;
    end
    if (push_c) begin
      tag_d[wr_ptr_q] = acc1_c;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      last_q   <= 1'b1;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      last_q   <= last_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      error_q  <= error_d;
    end
  end

endmodule

// File: tb/tb_sim_memory_arbiter.sv
// Bench for sim_memory_arbiter: queue-based reference model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_sim_memory_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        r0_req = 0, r0_rw = 0, r0_lk = 0;
  logic [1:0]  r0_ord = 0;
  logic [25:0] r0_addr = 0;
  logic [31:0] r0_data = 0;
  logic        r1_req = 0, r1_rw = 0, r1_lk = 0;
  logic [1:0]  r1_ord = 0;
  logic [25:0] r1_addr = 0;
  logic [31:0] r1_data = 0;
  logic        mem_lock = 0, mem_valid = 0;
  logic [63:0] mem_data = 0;

  logic        lock0, lock1, v0, v1, mreq, mrw, mlock, err;
  logic [63:0] d0, d1;
  logic [1:0]  mord;
  logic [25:0] maddr;
  logic [31:0] mdata;

  logic        f_lock0, f_lock1, f_v0, f_v1, f_mreq, f_mrw, f_mlock, f_err;
  logic [63:0] f_d0, f_d1;
  logic [1:0]  f_mord;
  logic [25:0] f_maddr;
  logic [31:0] f_mdata;

  sim_memory_arbiter u_dut (
    .iCLOCK(clk), .inRESET(rst_n),
    .iREQ0_REQ(r0_req), .oREQ0_LOCK(lock0), .iREQ0_ORDER(r0_ord), .iREQ0_RW(r0_rw),
    .iREQ0_ADDR(r0_addr), .iREQ0_DATA(r0_data), .oREQ0_VALID(v0), .iREQ0_LOCK(r0_lk),
    .oREQ0_DATA(d0),
    .iREQ1_REQ(r1_req), .oREQ1_LOCK(lock1), .iREQ1_ORDER(r1_ord), .iREQ1_RW(r1_rw),
    .iREQ1_ADDR(r1_addr), .iREQ1_DATA(r1_data), .oREQ1_VALID(v1), .iREQ1_LOCK(r1_lk),
    .oREQ1_DATA(d1),
    .oMEMORY_REQ(mreq), .iMEMORY_LOCK(mem_lock), .oMEMORY_ORDER(mord), .oMEMORY_RW(mrw),
    .oMEMORY_ADDR(maddr), .oMEMORY_DATA(mdata), .iMEMORY_VALID(mem_valid),
    .oMEMORY_LOCK(mlock), .iMEMORY_DATA(mem_data), .oERROR(err)
  );

  sim_memory_arbiter #(.P_FIXED_PRIO(1'b1)) u_fix (
    .iCLOCK(clk), .inRESET(rst_n),
    .iREQ0_REQ(r0_req), .oREQ0_LOCK(f_lock0), .iREQ0_ORDER(r0_ord), .iREQ0_RW(r0_rw),
    .iREQ0_ADDR(r0_addr), .iREQ0_DATA(r0_data), .oREQ0_VALID(f_v0), .iREQ0_LOCK(r0_lk),
    .oREQ0_DATA(f_d0),
    .iREQ1_REQ(r1_req), .oREQ1_LOCK(f_lock1), .iREQ1_ORDER(r1_ord), .iREQ1_RW(r1_rw),
    .iREQ1_ADDR(r1_addr), .iREQ1_DATA(r1_data), .oREQ1_VALID(f_v1), .iREQ1_LOCK(r1_lk),
    .oREQ1_DATA(f_d1),
    .oMEMORY_REQ(f_mreq), .iMEMORY_LOCK(mem_lock), .oMEMORY_ORDER(f_mord), .oMEMORY_RW(f_mrw),
    .oMEMORY_ADDR(f_maddr), .oMEMORY_DATA(f_mdata), .iMEMORY_VALID(mem_valid),
    .oMEMORY_LOCK(f_mlock), .iMEMORY_DATA(mem_data), .oERROR(f_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding reads as a queue of issuing ports
  bit          m_q[$];
  bit          m_last = 1'b1;
  bit          m_err  = 1'b0;
  bit          grant_log[$];
  bit          resp_port[$];
  logic [63:0] resp_data[$];
  bit          check_en = 0;
  bit          fix_en   = 0;

  bit          e_lock0, e_lock1, e_acc0, e_acc1, e_win1, e_empty, e_head, e_mlock, e_pop;

  task automatic eval_model();
    bit full;
    full    = (m_q.size() == 8);
    e_empty = (m_q.size() == 0);
    if (r0_req && r1_req) e_win1 = (m_last == 1'b0);
    else                  e_win1 = r1_req;
    e_lock0 = !rst_n || mem_lock || full || (r1_req && e_win1);
    e_lock1 = !rst_n || mem_lock || full || !e_win1;
    e_acc0  = r0_req && !e_lock0;
    e_acc1  = r1_req && !e_lock1;
    e_head  = e_empty ? 1'b0 : m_q[0];
    e_mlock = !e_empty && (e_head ? r1_lk : r0_lk);
    e_pop   = mem_valid && !e_empty && !e_mlock;
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (check_en) begin
      eval_model();
      chk("lock0", lock0, e_lock0);
      chk("lock1", lock1, e_lock1);
      chk("mem_req", mreq, e_acc0 || e_acc1);
      chk("mem_fields", {mord, mrw, maddr, mdata},
          e_win1 ? {r1_ord, r1_rw, r1_addr, r1_data} : {r0_ord, r0_rw, r0_addr, r0_data});
      chk("valid0", v0, rst_n && mem_valid && !e_empty && !e_head);
      chk("valid1", v1, rst_n && mem_valid && !e_empty && e_head);
      chk("data", {d0 ^ mem_data} | {d1 ^ mem_data}, 64'h0);
      chk("mem_lock", mlock, e_mlock);
      chk("error", err, rst_n && m_err);
      if (fix_en) begin
        chk("fix_lock0", f_lock0, 1'b0);
        chk("fix_lock1", f_lock1, 1'b1);
        chk("fix_fields", {f_mreq, f_mord, f_mrw, f_maddr, f_mdata},
            {1'b1, r0_ord, r0_rw, r0_addr, r0_data});
        chk("fix_resp", {f_v0, f_v1, f_mlock, f_err, f_d0 ^ mem_data, f_d1 ^ mem_data}, '0);
      end
    end
  end

  // Model state update at the active edge
  always @(posedge clk) begin
    if (check_en) begin
      eval_model();
      if (!rst_n) begin
        m_q.delete();
        m_err  = 1'b0;
        m_last = 1'b1;
      end else begin
        if (e_acc0) begin m_last = 1'b0; grant_log.push_back(1'b0); end
        if (e_acc1) begin m_last = 1'b1; grant_log.push_back(1'b1); end
        if (e_pop) begin
          resp_port.push_back(m_q[0]);
          resp_data.push_back(mem_data);
          void'(m_q.pop_front());
        end
        if (mem_valid && e_empty) m_err = 1'b1;
        if (e_acc0 && !r0_rw) m_q.push_back(1'b0);
        if (e_acc1 && !r1_rw) m_q.push_back(1'b1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    grant_log.delete();
    resp_port.delete();
    resp_data.delete();
  endtask

  task automatic chk_resp(input int idx, input bit port, input logic [63:0] data);
    if (resp_port.size() > idx) begin
      chk("resp_port", resp_port[idx], port);
      chk("resp_data", resp_data[idx], data);
    end else begin
      chk("resp_count", resp_port.size(), idx + 1);
    end
  endtask

  initial begin
    tick();
    check_en = 1;
    tick();
    @(negedge clk);
    chk("rst_locks", {lock0, lock1, mreq, v0, v1, err}, 6'b110000);
    tick();
    rst_n = 1'b1;

    // single read from REQ0
    r0_req = 1; r0_rw = 0; r0_ord = 2'b10; r0_addr = 26'h10;
    @(negedge clk);
    chk("t1_mreq", {mreq, maddr}, {1'b1, 26'h10});
    tick();
    r0_req = 0; mem_valid = 1; mem_data = 64'h1111_2222_3333_4444;
    @(negedge clk);
    chk("t1_valid", {v0, v1, d0}, {2'b10, 64'h1111_2222_3333_4444});
    tick();
    mem_valid = 0;

    // round-robin with both requesting continuously
    do_reset();
    r0_req = 1; r0_addr = 26'h20; r1_req = 1; r1_addr = 26'h40; r1_ord = 2'b01;
    fix_en = 1;
    repeat (4) tick();
    fix_en = 0;
    r0_req = 0; r1_req = 0;
    chk("t2_grant_n", grant_log.size(), 4);
    if (grant_log.size() == 4)
      chk("t2_grants", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 4'b0101);
    mem_valid = 1;
    for (int i = 0; i < 4; i++) begin
      mem_data = 64'hA0 + 64'(i);
      tick();
    end
    mem_valid = 0;
    chk_resp(0, 1'b0, 64'hA0);
    chk_resp(1, 1'b1, 64'hA1);
    chk_resp(3, 1'b1, 64'hA3);

    // interleaved reads with a stalled REQ1 response
    do_reset();
    r0_req = 1; r0_addr = 26'h100; tick();
    r0_req = 0; r1_req = 1; r1_addr = 26'h200; tick();
    r1_req = 0; r0_req = 1; r0_addr = 26'h300; tick();
    r0_req = 0;
    r1_lk = 1; mem_valid = 1; mem_data = 64'hA; tick();
    mem_data = 64'hB;
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall", {mlock, v0}, 2'b10);
      tick();
    end
    r1_lk = 0;
    @(negedge clk);
    chk("t3_release", {mlock, v1, v0}, 3'b010);
    tick();
    mem_data = 64'hC; tick();
    mem_valid = 0;
    chk_resp(0, 1'b0, 64'hA);
    chk_resp(1, 1'b1, 64'hB);
    chk_resp(2, 1'b0, 64'hC);

    // tag FIFO fills at 8 outstanding reads
    do_reset();
    r0_req = 1;
    for (int i = 0; i < 8; i++) begin
      r0_addr = 26'(i * 4);
      tick();
    end
    r0_addr = 26'h40;
    @(negedge clk);
    chk("t4_full_lock", lock0, 1'b1);
    tick();
    mem_valid = 1; mem_data = 64'h55;
    @(negedge clk);
    chk("t4_pop_no_bypass", lock0, 1'b1);
    tick();
    @(negedge clk);
    chk("t4_after_pop", {lock0, v0}, 2'b01);
    tick();
    mem_valid = 0;
    tick();
    @(negedge clk);
    chk("t4_refull", lock0, 1'b1);
    r0_req = 0;
    mem_valid = 1;
    repeat (8) tick();
    mem_valid = 0;
    chk("t4_grants", grant_log.size(), 10);
    chk("t4_resps", resp_port.size(), 10);

    // write from REQ0, read back from REQ1
    do_reset();
    r0_req = 1; r0_rw = 1; r0_addr = 26'h400; r0_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("t5_write", {mreq, mrw, mdata}, {2'b11, 32'hDEADBEEF});
    tick();
    r0_req = 0; r0_rw = 0; r0_lk = 1;
    @(negedge clk);
    chk("t5_no_tag", mlock, 1'b0);
    r0_lk = 0;
    r1_req = 1; r1_rw = 0; r1_addr = 26'h400; tick();
    r1_req = 0; mem_valid = 1; mem_data = 64'hDEADBEEF;
    @(negedge clk);
    chk("t5_read", {v1, v0, d1}, {2'b10, 64'hDEADBEEF});
    tick();
    mem_valid = 0;

    // stray response raises sticky error; reset clears tags and error
    mem_valid = 1; mem_data = 64'h77;
    @(negedge clk);
    chk("t6_stray_novalid", {v0, v1, err}, 3'b000);
    tick();
    mem_valid = 0;
    repeat (2) begin
      @(negedge clk);
      chk("t6_err_sticky", err, 1'b1);
      tick();
    end
    r0_req = 1; repeat (3) tick();
    r0_req = 0;
    rst_n = 0;
    @(negedge clk);
    chk("t6_err_in_reset", err, 1'b0);
    tick();
    rst_n = 1; r0_lk = 1;
    @(negedge clk);
    chk("t6_tags_cleared", {mlock, err}, 2'b00);
    r0_lk = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
